// File: rtl/se_fc_excite.sv
// se_fc_excite: serial fully-connected SE excitation stage, one MAC per cycle,
// parameters in an internal register file, results streamed out with valid/ready.
module se_fc_excite #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IN_CH      = 16,
  parameter int OUT_CH     = 4,
  parameter int APPLY_RELU = 1,
  localparam int NP = OUT_CH*IN_CH + OUT_CH,
  localparam int AW = $clog2(NP)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         w_wr_en,
  input  logic [AW-1:0]                w_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] w_wr_data,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);
  localparam int DW    = DATA_WIDTH;
  localparam int PW2   = 2*DW;
  localparam int IW    = IN_CH > 1 ? $clog2(IN_CH) : 1;
  localparam int OW    = OUT_CH > 1 ? $clog2(OUT_CH) : 1;
  localparam int ACC_W = 2*DW + $clog2(IN_CH) + 1;
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d, i_q, i_d;
  logic [OW-1:0]           o_q, o_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DW-1:0]    x_q [IN_CH];
  logic signed [DW-1:0]    x_d [IN_CH];
  logic signed [DW-1:0]    prm_q [NP];
  logic signed [DW-1:0]    prm_d [NP];
  logic signed [DW-1:0]    out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;

  logic [AW-1:0]           w_idx, b0_idx, bn_idx;
  logic signed [PW2-1:0]   prod;
  logic signed [ACC_W-1:0] acc_sum, rnd, sh, rl;
  logic signed [DW-1:0]    res;

  function automatic logic signed [ACC_W-1:0] bias_acc(input logic signed [DW-1:0] b);
    return {{(ACC_W-DW){b[DW-1]}}, b} << FRAC_BITS;
  endfunction

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Datapath: MAC, round half up, optional ReLU, saturate.
  always_comb begin
    w_idx   = AW'(o_q) * AW'(IN_CH) + AW'(i_q);
    b0_idx  = AW'(OUT_CH*IN_CH);
    bn_idx  = AW'(OUT_CH*IN_CH) + AW'(o_q) + AW'(1);
    prod    = PW2'(x_q[i_q]) * PW2'(prm_q[w_idx]);
    acc_sum = acc_q + ACC_W'(prod);
    rnd     = acc_sum + (ACC_W'(1) << (FRAC_BITS-1));
    sh      = rnd >>> FRAC_BITS;
    rl      = (APPLY_RELU != 0 && sh < 0) ? '0 : sh;
    res     = (rl > SMAX) ? SMAX[DW-1:0] : (rl < SMIN) ? SMIN[DW-1:0] : rl[DW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    o_d         = o_q;
    acc_d       = acc_q;
    x_d         = x_q;
    prm_d       = prm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (w_wr_en && 32'(w_wr_addr) < NP) prm_d[w_wr_addr] = w_wr_data;
        if (in_valid) begin
          x_d[0] = in_data;
          cnt_d  = IW'(1);
          if (IN_CH == 1) begin
            state_d = COMPUTE;
            o_d     = '0;
            i_d     = '0;
            acc_d   = bias_acc(prm_q[b0_idx]);
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          x_d[cnt_q] = in_data;
          cnt_d      = cnt_q + IW'(1);
          if (cnt_q == IW'(IN_CH-1)) begin
            state_d = COMPUTE;
            o_d     = '0;
            i_d     = '0;
            acc_d   = bias_acc(prm_q[b0_idx]);
          end
        end
      end
      COMPUTE: begin
        acc_d = acc_sum;
        i_d   = i_q + IW'(1);
        if (i_q == IW'(IN_CH-1)) begin
          out_data_d  = res;
          out_valid_d = 1'b1;
          out_last_d  = (o_q == OW'(OUT_CH-1));
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (o_q != OW'(OUT_CH-1)) begin
            o_d     = o_q + OW'(1);
            i_d     = '0;
            acc_d   = bias_acc(prm_q[bn_idx]);
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      x_q         <= '{default: '0};
      prm_q       <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      o_q         <= o_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      prm_q       <= prm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule
